// File: rtl/dcim_pkg.sv
// Shared constants, FSM state type and sign/zero-extension helper for the DCIM output path.
package dcim_pkg;

  localparam int unsigned DEF_IN_W  = 13;
  localparam int unsigned DEF_BITS  = 8;
  localparam int unsigned EXT_MAX_W = 64;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  // Extend the low w bits of x: replicate bit w-1 when sus = 1, zero-fill otherwise.
  function automatic logic [EXT_MAX_W-1:0] ext_w(input logic [EXT_MAX_W-1:0] x,
                                                 input int unsigned          w,
                                                 input logic                 sus);
    logic [EXT_MAX_W-1:0] mask;
    logic                 sb;
    mask = ~({EXT_MAX_W{1'b1}} << w);
    sb   = sus & ((x & ~(mask >> 1)) != '0);
    return (x & mask) | ({EXT_MAX_W{sb}} & ~mask);
  endfunction

endpackage

// File: rtl/dcim_plane_ext.sv
// Widens one adder-tree partial sum to accumulator width, optionally negated (signed MSB plane).
module dcim_plane_ext
  import dcim_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_IN_W + DEF_BITS
) (
  input  logic [IN_W-1:0]  data,
  input  logic             sus,
  input  logic             neg,
  output logic [OUT_W-1:0] plane_c
);

  logic [OUT_W-1:0] ext;

  always_comb begin
    ext     = OUT_W'(ext_w(EXT_MAX_W'(data), IN_W, sus));
    plane_c = neg ? OUT_W'(-ext) : ext;
  end

endmodule

// File: rtl/dcim_shift_acc.sv
// Bit-serial shift-accumulator folding MSB-first activation bit-planes into a full MAC result.
// Optional: define DCIM_SHACC_RELU_EN to clamp negative signed results to zero.
module dcim_shift_acc
  import dcim_pkg::*;
#(
  parameter int unsigned IN_W = DEF_IN_W,
  parameter int unsigned BITS = DEF_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sus,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IN_W+BITS-1:0] out_data,
  output logic                 out_sus
);

  localparam int unsigned OUT_W = IN_W + BITS;
  localparam int unsigned CNT_W = $clog2(BITS + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] acc;
  logic             sus_q;

  logic             take_c;
  logic             first_c;
  logic             last_c;
  logic [OUT_W-1:0] plane_c;
  logic [OUT_W-1:0] acc_next_c;
  logic [OUT_W-1:0] result_c;

  assign in_ready = ~out_valid | out_ready;
  assign take_c   = in_valid & in_ready;
  // Any accepted plane outside ACC starts a new frame (IDLE, or DONE while the result drains).
  assign first_c  = (state != ACC);
  assign last_c   = (cnt == CNT_W'(BITS - 1));

  dcim_plane_ext #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_plane_ext (
    .data    (in_data),
    .sus     (first_c ? sus : sus_q),
    .neg     (first_c & sus),
    .plane_c (plane_c)
  );

  always_comb begin
    acc_next_c = first_c ? plane_c : OUT_W'((acc << 1) + plane_c);
`ifdef DCIM_SHACC_RELU_EN
    result_c   = (sus_q & acc_next_c[OUT_W-1]) ? '0 : acc_next_c;
`else
    result_c   = acc_next_c;
`endif
  end

  // Frame FSM, plane counter, accumulator and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      sus_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sus   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take_c) begin
            sus_q <= sus;
            acc   <= acc_next_c;
            cnt   <= CNT_W'(1);
            state <= ACC;
          end
        end
        ACC: begin
          if (take_c) begin
            acc <= acc_next_c;
            if (last_c) begin
              cnt       <= '0;
              out_valid <= 1'b1;
              out_data  <= result_c;
              out_sus   <= sus_q;
              state     <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (take_c) begin
              sus_q <= sus;
              acc   <= acc_next_c;
              cnt   <= CNT_W'(1);
              state <= ACC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcim_shift_acc.sv
// Directed self-checking bench for dcim_shift_acc (IN_W = 13, BITS = 4).
module tb_dcim_shift_acc;

  localparam int unsigned IN_W  = 13;
  localparam int unsigned BITS  = 4;
  localparam int unsigned OUT_W = IN_W + BITS;

`ifdef DCIM_SHACC_RELU_EN
  localparam logic [OUT_W-1:0] SIGNED_EXP = '0;
`else
  localparam logic [OUT_W-1:0] SIGNED_EXP = 17'h1FFED;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sus;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sus;

  int total = 0;
  int bad   = 0;

  dcim_shift_acc #(.IN_W(IN_W), .BITS(BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sus       (sus),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sus   (out_sus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one plane, wait (bounded) for in_ready, then transfer it on the next edge.
  task automatic plane(input logic [IN_W-1:0] d, input logic s);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    sus      = s;
    n        = 0;
    #0;
    while (!in_ready && n < 50) begin
      step(1);
      n++;
    end
    if (n >= 50) check_val("in_ready_timeout", 32'(in_ready), 32'd1);
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic frame(input logic [IN_W-1:0] p0, input logic [IN_W-1:0] p1,
                       input logic [IN_W-1:0] p2, input logic [IN_W-1:0] p3,
                       input logic s);
    plane(p0, s);
    plane(p1, s);
    plane(p2, s);
    plane(p3, s);
  endtask

  initial begin
    rst_n     = 1'b0;
    sus       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_data",  32'(out_data),  32'd0);
    check_val("rst_out_sus",   32'(out_sus),   32'd0);
    rst_n = 1'b1;
    step(1);
    check_val("rst_in_ready",  32'(in_ready),  32'd1);

    // Unsigned frame 3,0,2,1 -> 29
    out_ready = 1'b1;
    plane(13'd3, 1'b0);
    plane(13'd0, 1'b0);
    plane(13'd2, 1'b0);
    check_val("u_no_early_valid", 32'(out_valid), 32'd0);
    plane(13'd1, 1'b0);
    check_val("u_valid", 32'(out_valid), 32'd1);
    check_val("u_data",  32'(out_data),  32'd29);
    check_val("u_sus",   32'(out_sus),   32'd0);
    step(1);
    check_val("u_taken", 32'(out_valid), 32'd0);

    // Signed frame 3,0,2,1 -> -19 (clamped to 0 with ReLU)
    frame(13'd3, 13'd0, 13'd2, 13'd1, 1'b1);
    check_val("s_valid", 32'(out_valid), 32'd1);
    check_val("s_data",  32'(out_data),  32'(SIGNED_EXP));
    check_val("s_sus",   32'(out_sus),   32'd1);

    // Signed, all planes -5 -> +5 (back-to-back with previous result drain)
    frame(13'h1FFB, 13'h1FFB, 13'h1FFB, 13'h1FFB, 1'b1);
    check_val("neg5_data", 32'(out_data), 32'd5);

    // Unsigned extremes -> 8191 * 15
    frame(13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF, 1'b0);
    check_val("umax_data", 32'(out_data), 32'd122865);
    check_val("umax_sus",  32'(out_sus),  32'd0);

    // Backpressure: frame 1,2,3,4 -> 26, held while out_ready = 0
    step(1);
    out_ready = 1'b0;
    frame(13'd1, 13'd2, 13'd3, 13'd4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_val("bp_valid",    32'(out_valid), 32'd1);
      check_val("bp_data",     32'(out_data),  32'd26);
      check_val("bp_in_ready", 32'(in_ready),  32'd0);
      step(1);
    end
    // Release with next frame's first plane in the same cycle: 2,0,0,0 -> 16
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 13'd2;
    sus       = 1'b0;
    #1;
    check_val("bp_release_ready", 32'(in_ready), 32'd1);
    step(1);
    in_valid = 1'b0;
    check_val("bp_taken", 32'(out_valid), 32'd0);
    plane(13'd0, 1'b0);
    plane(13'd0, 1'b0);
    plane(13'd0, 1'b0);
    check_val("bp_next_valid", 32'(out_valid), 32'd1);
    check_val("bp_next_data",  32'(out_data),  32'd16);

    // Bubbles plus sus toggled after plane 0 -> same as gap-free signed frame
    step(1);
    plane(13'd3, 1'b1);
    step(2);
    plane(13'd0, 1'b0);
    step(1);
    plane(13'd2, 1'b0);
    step(3);
    check_val("gap_no_early_valid", 32'(out_valid), 32'd0);
    plane(13'd1, 1'b0);
    check_val("gap_data", 32'(out_data), 32'(SIGNED_EXP));
    check_val("gap_sus",  32'(out_sus),  32'd1);

    // Reset after two planes discards the partial frame
    step(1);
    plane(13'd5, 1'b1);
    plane(13'd7, 1'b1);
    rst_n = 1'b0;
    #1;
    check_val("mrst_valid", 32'(out_valid), 32'd0);
    check_val("mrst_data",  32'(out_data),  32'd0);
    check_val("mrst_sus",   32'(out_sus),   32'd0);
    check_val("mrst_ready", 32'(in_ready),  32'd1);
    step(1);
    rst_n = 1'b1;
    step(1);
    frame(13'd1, 13'd1, 13'd1, 13'd1, 1'b0);
    check_val("mrst_frame_valid", 32'(out_valid), 32'd1);
    check_val("mrst_frame_data",  32'(out_data),  32'd15);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcim_shift_acc.md
Name: dcim_shift_acc

Overview:
- Bit-serial shift-accumulator on the output side of the DCIM macro adder tree.
- Consumes one adder-tree partial sum per input-activation bit-plane, MSB plane first.
- Folds the planes into a full-precision MAC result and presents it on a valid/ready output.
- Signed/unsigned handling follows the same `sus` convention as the adder (0 = unsigned, 1 = two's complement); in signed mode the MSB plane carries negative weight and is subtracted.

Parameters:
- IN_W, 13, partial-sum width; equals adder width + 1.
- BITS, 8, activation bit-planes per frame; legal range 2..16.
- OUT_W, IN_W+BITS, result width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sus  in  1  0 = unsigned, 1 = signed; sampled only with the first plane of a frame.
- in_valid  in  1  partial-sum valid.
- in_ready  out  1  block can accept a plane.
- in_data  in  IN_W  partial sum for the current plane.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  OUT_W  accumulated result; two's complement when sus_q = 1.
- out_sus  out  1  sus value latched for the frame being presented.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state = IDLE, plane counter = 0, acc = 0, sus_q = 0.
  - out_valid = 0, out_data = 0, out_sus = 0, in_ready = 1 (once rst_n = 1).
- Plane transfer occurs on in_valid & in_ready. Result transfer occurs on out_valid & out_ready.
- in_ready = ~out_valid | out_ready, so a new frame's first plane may be accepted in the same cycle the previous result is taken.
- States:
  - IDLE: counter = 0, out_valid = 0. A plane transfer latches sus into sus_q and loads acc with the first-plane value; goes to ACC with counter = 1.
  - ACC: each plane transfer does acc <= (acc << 1) + ext(in_data) and counter++. The transfer that makes counter == BITS goes to DONE, sets out_valid = 1, and resets counter to 0.
  - DONE: out_data = acc and out_sus = sus_q, both held stable while out_ready = 0.
    - out_ready = 1 and no plane transfer: go to IDLE, out_valid <= 0.
    - out_ready = 1 and a plane transfer in the same cycle: behave as IDLE's first-plane load; go to ACC, out_valid <= 0.
- Plane value arithmetic:
  - ext(x) = sign-extend x to OUT_W when sus_q = 1, zero-extend when sus_q = 0. The first plane uses the incoming sus rather than sus_q.
  - First plane = -ext(in_data) when sus = 1, +ext(in_data) when sus = 0.
  - All arithmetic is modulo 2^OUT_W. OUT_W is sufficient, so no overflow is possible for any legal input.
- Latency: out_valid rises on the clock edge that accepts plane BITS-1 (the last plane), i.e. the next cycle. Minimum frame period is BITS cycles.
- in_valid gaps: acc and counter hold.
- sus changes mid-frame: ignored.
- Reset mid-frame: partial accumulation is discarded; the next plane after reset is treated as a first plane.

Optional Feature:
- Macro: DCIM_SHACC_RELU_EN.
- Defined: the final value presented on out_data is clamped to 0 when sus_q = 1 and the result is negative. The clamp is applied when entering DONE, with no extra latency. Unsigned frames are unaffected.
- Undefined: out_data is the raw accumulated value; no clamp logic is synthesised.

Decomposition:
- Shared package dcim_pkg:
  - default IN_W and BITS constants;
  - state enum type {IDLE, ACC, DONE};
  - sign/zero-extension function ext_w(x, sus).
- One natural sub-module: dcim_plane_ext, a combinational sign/zero-extend plus conditional negate feeding the accumulator adder. Counter and FSM stay in the top.

Test Plan (IN_W = 13, BITS = 4):
- Unsigned frame: sus = 0, planes 3, 0, 2, 1 back-to-back, out_ready = 1 -> one cycle after the 4th plane, out_valid = 1, out_data = 29, out_sus = 0.
- Signed frame: sus = 1, planes 3, 0, 2, 1 -> out_data = -19 (17'h1FFED). With DCIM_SHACC_RELU_EN defined, out_data = 0.
- Negative partial sums: sus = 1, all four planes -5 (13'h1FFB) -> out_data = +5. Unsigned extremes: sus = 0, all planes 8191 -> out_data = 122865.
- Backpressure: hold out_ready = 0 for 3 cycles after out_valid -> out_data stable, in_ready = 0. Raise out_ready with the next frame's first plane presented in the same cycle -> result taken and the new frame starts that cycle, with no lost plane.
- Bubbles and mid-frame sus change: insert in_valid = 0 gaps between planes and toggle sus after plane 0 -> the result matches the gap-free frame that used the first-plane sus.
- Reset mid-frame: assert rst_n = 0 after 2 planes -> all outputs return to reset values immediately. A following full frame 1, 1, 1, 1 with sus = 0 -> out_data = 15.
